// File: rtl/weight_fetch.sv
// ---------------------------------------------------------------------------
// weight_fetch
//
// Read-only SRAM master that streams a contiguous block of words out of a
// single-port SRAM onto a valid/ready stream. A fetch is described by a base
// word address and a word count. Addresses wrap modulo DEPTH. A small output
// FIFO absorbs downstream backpressure. Reads are issued only when the FIFO
// plus all words already in flight can still accept one more word.
//
// Ports
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   start      : one-cycle fetch request (sampled only while idle)
//   base_addr  : first word address, sampled with start
//   len        : number of words to fetch (0..16384), sampled with start
//   busy       : high while a fetch is in progress
//   done       : one-cycle completion pulse
//   sram_addr  : SRAM read address (data returns one cycle later)
//   sram_wea   : SRAM byte write enables, always zero
//   sram_rdata : SRAM read data for the previous cycle's address
//   m_valid    : output stream valid
//   m_ready    : output stream ready
//   m_data     : output stream word
//   m_last     : marks the final word of the fetch
// ---------------------------------------------------------------------------
module weight_fetch #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16384,
    parameter int FIFO_D = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [14:0]       len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [3:0]        sram_wea,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last
);

    localparam int PTR_W = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
    localparam int CNT_W = $clog2(FIFO_D + 1);

    // DEPTH is a power of two, so the modulo on addresses is a mask.
    localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(DEPTH - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]        state;
    logic [14:0]       rd_left;     // reads still to be issued
    logic [14:0]       beats_left;  // beats still to be handshaken
    logic              issue_q;     // an address is on sram_addr this cycle
    logic              rvalid_q;    // sram_rdata carries a requested word

    logic [DATA_W-1:0] fifo_mem [FIFO_D];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_count;

    logic              accept;
    logic              room;
    logic              issue_go;
    logic              push;
    logic              pop;
    logic              last_pop;

    // Every word already requested (address presented or data returning)
    // holds a FIFO slot in advance, so the FIFO can never overflow.
    assign room = (32'(fifo_count) + 32'(issue_q) + 32'(rvalid_q)) < 32'(FIFO_D);

    assign accept   = (state == ST_IDLE) && start && (len != 15'd0);
    assign issue_go = accept || ((state == ST_FETCH) && (rd_left != 15'd0) && room);

    assign push     = rvalid_q;
    assign pop      = m_valid && m_ready;
    assign last_pop = pop && (beats_left == 15'd1);

    assign busy     = (state != ST_IDLE);
    assign sram_wea = 4'b0000;
    assign m_valid  = (fifo_count != '0);
    assign m_last   = m_valid && (beats_left == 15'd1);
    // The FIFO head is gated so m_data reads zero whenever no beat is offered.
    assign m_data   = m_valid ? fifo_mem[rd_ptr] : '0;

    // -----------------------------------------------------------------------
    // Control: FSM, counters, address generation, read pipeline
    // -----------------------------------------------------------------------
    // NOTE: clocked state is written only with <= so every register samples
    // the pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            done       <= 1'b0;
            rd_left    <= '0;
            beats_left <= '0;
            sram_addr  <= '0;
            issue_q    <= 1'b0;
            rvalid_q   <= 1'b0;
        end else begin
            done     <= 1'b0;
            issue_q  <= issue_go;
            rvalid_q <= issue_q;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (len == 15'd0) begin
                            done <= 1'b1;
                        end else begin
                            state      <= ST_FETCH;
                            rd_left    <= len - 15'd1;
                            beats_left <= len;
                        end
                    end
                end
                ST_FETCH: begin
                    if (issue_go) begin
                        rd_left <= rd_left - 15'd1;
                    end
                    if (rd_left == 15'd0) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Waiting for the remaining words to drain downstream.
                end
                default: state <= ST_IDLE;
            endcase

            if (pop) begin
                beats_left <= beats_left - 15'd1;
            end

            if (last_pop) begin
                state <= ST_IDLE;
                done  <= 1'b1;
            end

            // sram_addr only moves when a read is issued, otherwise it holds.
            if (issue_go) begin
                sram_addr <= accept ? (base_addr & ADDR_MASK)
                                    : ((sram_addr + 1'b1) & ADDR_MASK);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Output FIFO bookkeeping
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(FIFO_D - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(FIFO_D - 1)) ? '0 : rd_ptr + 1'b1;
            end
            // A simultaneous push and pop leaves the count unchanged.
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; a cleared count makes its
    // contents unreachable, and m_data is gated while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= sram_rdata;
        end
    end

endmodule

// File: tb/tb_weight_fetch.sv
// ---------------------------------------------------------------------------
// tb_weight_fetch
//
// Directed fetch scenarios against weight_fetch with a randomly filled SRAM
// model. The reference is a queue of the words each accepted fetch must
// produce, computed as mem[(base + i) mod DEPTH]; a negedge monitor compares
// every handshake, stall, done pulse and busy level against that model.
// ---------------------------------------------------------------------------
module tb_weight_fetch;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 16384;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b1;
    logic              start     = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [14:0]       len       = '0;
    logic              m_ready   = 1'b0;
    logic [DATA_W-1:0] sram_rdata;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] sram_addr;
    logic [3:0]        sram_wea;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_last;

    always #5 clk = ~clk;

    weight_fetch #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .FIFO_D (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .sram_addr  (sram_addr),
        .sram_wea   (sram_wea),
        .sram_rdata (sram_rdata),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last)
    );

    // SRAM with one cycle of read latency.
    logic [DATA_W-1:0] mem [DEPTH];
    always @(posedge clk) sram_rdata <= mem[sram_addr[13:0]];

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [DATA_W-1:0] exp_q [$];
    bit                model_busy = 1'b0;
    bit                done_due   = 1'b0;
    int                beats_seen = 0;
    int                done_seen  = 0;
    bit                prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data  = '0;
    logic              prev_last  = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"},   busy,      0);
        check({tag, "_done"},   done,      0);
        check({tag, "_valid"},  m_valid,   0);
        check({tag, "_last"},   m_last,    0);
        check({tag, "_data"},   m_data,    0);
        check({tag, "_addr"},   sram_addr, 0);
        check({tag, "_wea"},    sram_wea,  0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        exp_q.delete();
        model_busy = 1'b0;
        done_due   = 1'b0;
        prev_stall = 1'b0;
    endtask

    // Pulse start for one cycle; returns 1 ns into cycle 1 of the fetch.
    task automatic start_fetch(input logic [15:0] b, input logic [14:0] n);
        bit acc;
        acc       = !model_busy;
        start     = 1'b1;
        base_addr = b;
        len       = n;
        tick();
        start     = 1'b0;
        len       = '0;
        if (acc) begin
            if (n == 15'd0) begin
                done_due = 1'b1;
            end else begin
                for (int i = 0; i < int'(n); i++) begin
                    exp_q.push_back(mem[(int'(b) + i) % DEPTH]);
                end
                model_busy = 1'b1;
            end
        end
    endtask

    task automatic wait_idle(input string tag, input int max_cycles);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (!model_busy && !done_due) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check({tag, "_completes"}, ok, 1);
    endtask

    // Monitor: compares the DUT against the model once per cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            check_zero("in_reset");
            clear_model();
        end else begin
            check("wea_zero", sram_wea, 0);
            check("addr_hi_zero", sram_addr[15:14], 0);
            check("busy", busy, model_busy);
            check("done", done, done_due);
            if (done) done_seen++;
            done_due = 1'b0;
            if (prev_stall) begin
                check("hold_valid", m_valid, 1);
                check("hold_data", m_data, prev_data);
                check("hold_last", m_last, prev_last);
            end
            if (exp_q.size() == 0) begin
                check("no_beat_expected", m_valid, 0);
            end else if (m_valid && m_ready) begin
                check("beat_data", m_data, exp_q[0]);
                check("beat_last", m_last, exp_q.size() == 1);
                void'(exp_q.pop_front());
                beats_seen++;
                if (exp_q.size() == 0) begin
                    model_busy = 1'b0;
                    done_due   = 1'b1;
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    initial begin
        int b0;
        int d0;

        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;

        // Reset state.
        #2 rst_n = 1'b0;
        #1 check_zero("por");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Streaming: base 0x10, len 8, m_ready high.
        m_ready = 1'b1;
        b0 = beats_seen;
        d0 = done_seen;
        start_fetch(16'h0010, 15'd8);
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (c <= 8) check("stream_addr", sram_addr, 16'h0010 + c - 1);
            check("stream_valid", m_valid, (c >= 3) && (c <= 10));
            check("stream_last", m_last, c == 10);
            check("stream_done", done, c == 11);
            check("stream_busy", busy, c <= 10);
            tick();
        end
        wait_idle("stream", 10);
        check("stream_beats", beats_seen - b0, 8);
        check("stream_dones", done_seen - d0, 1);

        // Backpressure: base 0x100, len 6, m_ready low for 10 cycles.
        m_ready = 1'b0;
        b0 = beats_seen;
        start_fetch(16'h0100, 15'd6);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            check("bp_read_bound", sram_addr <= 16'h0103, 1);
            if (c >= 3) check("bp_valid", m_valid, 1);
            tick();
        end
        m_ready = 1'b1;
        wait_idle("bp", 40);
        check("bp_beats", beats_seen - b0, 6);

        // Wrap: base 16382, len 4.
        b0 = beats_seen;
        start_fetch(16'd16382, 15'd4);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check("wrap_addr", sram_addr, (16382 + c - 1) % DEPTH);
            tick();
        end
        wait_idle("wrap", 20);
        check("wrap_beats", beats_seen - b0, 4);

        // Zero length: done next cycle, no beats.
        b0 = beats_seen;
        d0 = done_seen;
        start_fetch(16'h0020, 15'd0);
        wait_idle("zero", 5);
        repeat (3) tick();
        check("zero_beats", beats_seen - b0, 0);
        check("zero_dones", done_seen - d0, 1);

        // Start while busy is ignored.
        b0 = beats_seen;
        d0 = done_seen;
        start_fetch(16'h0030, 15'd3);
        tick();
        start_fetch(16'h0040, 15'd5);
        wait_idle("ignore", 30);
        repeat (8) tick();
        check("ignore_beats", beats_seen - b0, 3);
        check("ignore_dones", done_seen - d0, 1);

        // Reset during beat 2 of a len 8 fetch.
        b0 = beats_seen;
        start_fetch(16'h0200, 15'd8);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        clear_model();
        #1 check_zero("mid_reset");
        tick();
        tick();
        rst_n = 1'b1;
        repeat (12) tick();
        check("reset_beats", beats_seen - b0, 1);

        // Full-depth fetch with random m_ready.
        b0 = beats_seen;
        d0 = done_seen;
        start_fetch(16'h0000, 15'd16384);
        begin
            bit ok;
            ok = 1'b0;
            for (int i = 0; i < 60000; i++) begin
                m_ready = ($urandom_range(0, 3) != 0);
                if (!model_busy && !done_due) begin
                    ok = 1'b1;
                    break;
                end
                tick();
            end
            check("full_completes", ok, 1);
        end
        m_ready = 1'b1;
        repeat (4) tick();
        check("full_beats", beats_seen - b0, 16384);
        check("full_dones", done_seen - d0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/weight_fetch.md
WEIGHT_FETCH -- requirements
Module: weight_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, meaning the SRAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning the SRAM word width.
REQ-003 SHALL have parameter DEPTH, default 16384, meaning the number of SRAM words (power of two).
REQ-004 SHALL have parameter FIFO_D, default 4, meaning the output buffer depth in words.
REQ-005 clk  input  1  single clock; all logic is rising-edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 start  input  1  one-cycle request to begin a fetch; sampled only in IDLE.
REQ-008 base_addr  input  ADDR_W  first word address, sampled with start.
REQ-009 len  input  15  word count 0..16384, sampled with start.
REQ-010 busy  output  1  high from the cycle after an accepted start until done.
REQ-011 done  output  1  one-cycle pulse when the last beat is accepted, or when a zero-length fetch completes.
REQ-012 sram_addr  output  ADDR_W  SRAM read address; read data returns exactly 1 cycle later.
REQ-013 sram_wea  output  4  byte write enables; tied to 4'b0000 (read-only master).
REQ-014 sram_rdata  input  DATA_W  SRAM read data for the address presented in the previous cycle.
REQ-015 m_valid / m_ready / m_data(DATA_W) / m_last(1)  output/input/output/output  valid-ready output stream; m_last marks the final word.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, DRAIN.
- IDLE->FETCH on start with len>0.
- FETCH->DRAIN in the cycle after the last read is issued.
- DRAIN->IDLE when the last beat handshakes.
REQ-017 start with len==0 SHALL stay in IDLE, pulse done on the next cycle, and produce no beats.
REQ-018 start while busy SHALL be ignored, with no effect on the fetch in progress.
REQ-019 Read i (i=0..len-1) SHALL use sram_addr = (base_addr + i) mod DEPTH, with upper address bits zero.
- Wrap: 16383 -> 0.
REQ-020 A read SHALL be issued in a cycle only if inflight + fifo_count + issue_pending < FIFO_D, so the buffer never overflows.
REQ-021 Returned sram_rdata SHALL be written into the FIFO 1 cycle after its issue.
- Latency from an accepted start (cycle 0): first sram_addr valid in cycle 1, first m_valid in cycle 3.
REQ-022 With m_ready held high, the block SHALL sustain one beat per clock after the first beat.
REQ-023 m_data/m_last SHALL stay stable while m_valid=1 and m_ready=0.
- A beat transfers only on m_valid && m_ready.
REQ-024 Beats SHALL emerge in address order; m_last=1 only on beat len-1.
REQ-025 A beat handshaking in the same cycle a new word enters the FIFO SHALL leave the count unchanged, with no loss or duplication.
REQ-026 done SHALL pulse in the cycle after the last handshake; busy falls in that same cycle.
REQ-027 When no read is issued, sram_addr SHALL hold its last value.

Reset
REQ-028 While rst_n=0, regardless of clk:
- state=IDLE
- busy=0, done=0, m_valid=0, m_last=0, m_data=0
- sram_addr=0, sram_wea=0
- FIFO count and all counters = 0
REQ-029 Reset asserted mid-fetch SHALL abandon the fetch; no beat, done or stale FIFO word SHALL appear after reset deassertion.

Verification
REQ-030 Streaming:
- Stimulus: base=0x0010, len=8, m_ready=1.
- Required: sram_addr 0x10..0x17 in cycles 1..8; beats on cycles 3..10 with data=mem[0x10..0x17]; m_last on cycle 10; done on cycle 11.
REQ-031 Backpressure:
- Stimulus: base=0x0100, len=6, m_ready=0 for 10 cycles then 1.
- Required: at most 4 reads issued before the first beat; data held stable while stalled; all 6 words in order; no overflow.
REQ-032 Wrap:
- Stimulus: base=16382, len=4.
- Required: addresses 16382, 16383, 0, 1; data matches; m_last on the 4th beat.
REQ-033 Zero length and ignored start:
- Stimulus: len=0, then a start pulsed during a len=3 fetch.
- Required: done next cycle with no beats; the second start is ignored and exactly 3 beats appear.
REQ-034 Reset mid-operation:
- Stimulus: rst_n=0 during beat 2 of len=8.
- Required: all outputs 0 immediately; nothing emitted after release until a new start.
REQ-035 Random m_ready toggling, len=16384, base=0:
- Required: 16384 beats in order, one done, and sram_wea=0 throughout.
